// File: rtl/pipe_hazard_ctrl.sv
// Hazard control for a five-stage in-order pipeline: operand forwarding,
// load-use interlock, branch flush and data-memory wait, plus a stall counter.
module pipe_hazard_ctrl (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic [4:0]  idex_rs1_i,
  input  logic [4:0]  idex_rs2_i,
  input  logic [4:0]  idex_rd_i,
  input  logic        idex_memread_i,
  input  logic        idex_regwrite_i,
  input  logic [4:0]  exmem_rd_i,
  input  logic        exmem_regwrite_i,
  input  logic [4:0]  memwb_rd_i,
  input  logic        memwb_regwrite_i,
  input  logic        pcBranch_i,
  input  logic        mem_req_i,
  input  logic        mem_ready_i,
  input  logic        cnt_clr_i,
  output logic [1:0]  fwdA_o,
  output logic [1:0]  fwdB_o,
  output logic        pc_en_o,
  output logic        ifid_en_o,
  output logic        idex_en_o,
  output logic        exmem_en_o,
  output logic        memwb_en_o,
  output logic        flush_id_o,
  output logic        flush_ex_o,
  output logic [15:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   memstall;
  logic   loaduse;
  logic [15:0] stall_cnt_q;

  // EX/MEM holds the younger result, so it wins over MEM/WB; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (exmem_regwrite_i && (exmem_rd_i != 5'd0) && (exmem_rd_i == src))
      return 2'b10;
    else if (memwb_regwrite_i && (memwb_rd_i != 5'd0) && (memwb_rd_i == src))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign fwdA_o = fwd_sel(idex_rs1_i);
  assign fwdB_o = fwd_sel(idex_rs2_i);

  assign memstall = mem_req_i & ~mem_ready_i;
  assign loaduse  = idex_memread_i & (idex_rd_i != 5'd0) &
                    ((idex_rd_i == id_rs1_i) | (idex_rd_i == id_rs2_i));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= RUN;
    else         state_q <= state_d;
  end

  // MEM_WAIT exits into RUN rules on the first ready cycle, so a branch there flushes.
  always_comb begin
    state_d = state_q;
    if (memstall) begin
      state_d = MEM_WAIT;
    end else begin
      unique case (state_q)
        RUN, MEM_WAIT: state_d = pcBranch_i ? FLUSH : RUN;
        FLUSH:         state_d = RUN;
        default:       state_d = RUN;
      endcase
    end
  end

  always_comb begin
    pc_en_o    = 1'b1;
    ifid_en_o  = 1'b1;
    idex_en_o  = 1'b1;
    exmem_en_o = 1'b1;
    memwb_en_o = 1'b1;
    flush_id_o = 1'b0;
    flush_ex_o = 1'b0;
    if (!reset_i) begin
      if (memstall) begin
        pc_en_o    = 1'b0;
        ifid_en_o  = 1'b0;
        idex_en_o  = 1'b0;
        exmem_en_o = 1'b0;
        memwb_en_o = 1'b0;
      end else if (state_q == FLUSH) begin
        flush_id_o = 1'b1;
      end else if (pcBranch_i) begin
        flush_id_o = 1'b1;
        flush_ex_o = 1'b1;
      end else if (loaduse) begin
        pc_en_o    = 1'b0;
        ifid_en_o  = 1'b0;
        flush_ex_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)
      stall_cnt_q <= 16'd0;
    else if (cnt_clr_i)
      stall_cnt_q <= 16'd0;
    else if (!pc_en_o && (stall_cnt_q != 16'hFFFF))
      stall_cnt_q <= stall_cnt_q + 16'd1;
  end

  assign stall_cnt_o = stall_cnt_q;

  logic unused_ok;
  assign unused_ok = idex_regwrite_i;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random
// traffic compared against a rule-level reference model.
module tb_pipe_hazard_ctrl;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [4:0]  id_rs1_i, id_rs2_i, idex_rs1_i, idex_rs2_i, idex_rd_i;
  logic        idex_memread_i, idex_regwrite_i;
  logic [4:0]  exmem_rd_i, memwb_rd_i;
  logic        exmem_regwrite_i, memwb_regwrite_i;
  logic        pcBranch_i, mem_req_i, mem_ready_i, cnt_clr_i;
  logic [1:0]  fwdA_o, fwdB_o;
  logic        pc_en_o, ifid_en_o, idex_en_o, exmem_en_o, memwb_en_o;
  logic        flush_id_o, flush_ex_o;
  logic [15:0] stall_cnt_o;

  int total = 0;
  int bad   = 0;

  // Model: count of stalled cycles and whether the previous cycle accepted a branch.
  int   m_cnt;
  bit   m_shadow;
  logic [1:0] e_fwdA, e_fwdB;
  logic [4:0] e_en;
  logic [1:0] e_fl;

  typedef struct packed {
    logic [4:0] id_rs1, id_rs2, idex_rs1, idex_rs2, idex_rd;
    logic       idex_memread, idex_regwrite;
    logic [4:0] exmem_rd;
    logic       exmem_wr;
    logic [4:0] memwb_rd;
    logic       memwb_wr;
    logic       branch, mem_req, mem_ready, clr;
  } stim_t;

  stim_t s;

  pipe_hazard_ctrl dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .idex_rs1_i(idex_rs1_i), .idex_rs2_i(idex_rs2_i), .idex_rd_i(idex_rd_i),
    .idex_memread_i(idex_memread_i), .idex_regwrite_i(idex_regwrite_i),
    .exmem_rd_i(exmem_rd_i), .exmem_regwrite_i(exmem_regwrite_i),
    .memwb_rd_i(memwb_rd_i), .memwb_regwrite_i(memwb_regwrite_i),
    .pcBranch_i(pcBranch_i), .mem_req_i(mem_req_i), .mem_ready_i(mem_ready_i),
    .cnt_clr_i(cnt_clr_i),
    .fwdA_o(fwdA_o), .fwdB_o(fwdB_o),
    .pc_en_o(pc_en_o), .ifid_en_o(ifid_en_o), .idex_en_o(idex_en_o),
    .exmem_en_o(exmem_en_o), .memwb_en_o(memwb_en_o),
    .flush_id_o(flush_id_o), .flush_ex_o(flush_ex_o),
    .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic applyStimulus(input stim_t v);
    id_rs1_i         = v.id_rs1;
    id_rs2_i         = v.id_rs2;
    idex_rs1_i       = v.idex_rs1;
    idex_rs2_i       = v.idex_rs2;
    idex_rd_i        = v.idex_rd;
    idex_memread_i   = v.idex_memread;
    idex_regwrite_i  = v.idex_regwrite;
    exmem_rd_i       = v.exmem_rd;
    exmem_regwrite_i = v.exmem_wr;
    memwb_rd_i       = v.memwb_rd;
    memwb_regwrite_i = v.memwb_wr;
    pcBranch_i       = v.branch;
    mem_req_i        = v.mem_req;
    mem_ready_i      = v.mem_ready;
    cnt_clr_i        = v.clr;
  endtask

  function automatic logic [1:0] refFwd(input logic [4:0] src);
    if (s.exmem_wr && s.exmem_rd != 0 && s.exmem_rd == src) return 2'b10;
    if (s.memwb_wr && s.memwb_rd != 0 && s.memwb_rd == src) return 2'b01;
    return 2'b00;
  endfunction

  // e_en = {pc, ifid, idex, exmem, memwb}; e_fl = {flush_id, flush_ex}
  task automatic computeExpected();
    bit memstall, loaduse;
    memstall = s.mem_req && !s.mem_ready;
    loaduse  = s.idex_memread && s.idex_rd != 0 &&
               (s.idex_rd == s.id_rs1 || s.idex_rd == s.id_rs2);
    e_fwdA = refFwd(s.idex_rs1);
    e_fwdB = refFwd(s.idex_rs2);
    e_en = 5'b11111;
    e_fl = 2'b00;
    if (reset_i) ;
    else if (memstall) e_en = 5'b00000;
    else if (m_shadow) e_fl = 2'b10;
    else if (s.branch) e_fl = 2'b11;
    else if (loaduse) begin e_en = 5'b00111; e_fl = 2'b01; end
  endtask

  task automatic updateModel();
    bit memstall;
    memstall = s.mem_req && !s.mem_ready;
    if (reset_i) begin
      m_cnt = 0; m_shadow = 0;
    end else begin
      if (s.clr) m_cnt = 0;
      else if (!e_en[4] && m_cnt < 65535) m_cnt = m_cnt + 1;
      m_shadow = !memstall && !m_shadow && s.branch;
    end
  endtask

  task automatic checkOne(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkOutput();
    computeExpected();
    checkOne("fwdA", {14'd0, fwdA_o}, {14'd0, e_fwdA});
    checkOne("fwdB", {14'd0, fwdB_o}, {14'd0, e_fwdB});
    checkOne("enables", {11'd0, pc_en_o, ifid_en_o, idex_en_o, exmem_en_o, memwb_en_o},
             {11'd0, e_en});
    checkOne("flushes", {14'd0, flush_id_o, flush_ex_o}, {14'd0, e_fl});
    checkOne("stall_cnt", stall_cnt_o, m_cnt[15:0]);
  endtask

  // Inputs are applied just after a falling edge; outputs sampled 1 time unit later.
  task automatic stepCycle(input bit do_check);
    applyStimulus(s);
    #1;
    if (do_check) checkOutput();
    else computeExpected();
    @(posedge clk_i);
    updateModel();
    @(negedge clk_i);
  endtask

  task automatic randomStim();
    s.id_rs1       = 5'($urandom_range(0, 3));
    s.id_rs2       = 5'($urandom_range(0, 3));
    s.idex_rs1     = 5'($urandom_range(0, 3));
    s.idex_rs2     = 5'($urandom_range(0, 3));
    s.idex_rd      = 5'($urandom_range(0, 3));
    s.idex_memread = ($urandom_range(0, 2) == 0);
    s.idex_regwrite = 1'($urandom);
    s.exmem_rd     = 5'($urandom_range(0, 3));
    s.exmem_wr     = 1'($urandom);
    s.memwb_rd     = 5'($urandom_range(0, 3));
    s.memwb_wr     = 1'($urandom);
    s.branch       = ($urandom_range(0, 3) == 0);
    s.mem_req      = ($urandom_range(0, 2) == 0);
    s.mem_ready    = 1'($urandom);
    s.clr          = ($urandom_range(0, 15) == 0);
  endtask

  initial begin
    m_cnt = 0; m_shadow = 0;
    s = '0;
    s.mem_req = 1'b1;
    reset_i = 1'b1;
    applyStimulus(s);
    @(negedge clk_i);
    #1;
    // Reset with a pending memory access still shows free-running enables.
    checkOutput();
    @(negedge clk_i);
    reset_i = 1'b0;
    s.mem_req = 1'b0;

    // Forwarding priority and x0 suppression
    s.exmem_rd = 5; s.exmem_wr = 1; s.memwb_rd = 5; s.memwb_wr = 1; s.idex_rs1 = 5;
    stepCycle(1);
    checkOne("fwdA_exmem", {14'd0, fwdA_o}, 16'h2);
    s.exmem_wr = 0;
    stepCycle(1);
    checkOne("fwdA_memwb", {14'd0, fwdA_o}, 16'h1);
    s.exmem_rd = 0; s.memwb_rd = 0; s.exmem_wr = 1; s.idex_rs1 = 0;
    stepCycle(1);
    checkOne("fwdA_x0", {14'd0, fwdA_o}, 16'h0);

    // Load-use: one bubble, counter 0 -> 1
    s = '0;
    s.idex_memread = 1; s.idex_rd = 7; s.id_rs2 = 7;
    stepCycle(1);
    s = '0;
    stepCycle(1);
    checkOne("loaduse_cnt", stall_cnt_o, 16'd1);

    // Branch: two-cycle flush pattern, then clean
    s.branch = 1;
    stepCycle(1);
    s.branch = 1;
    stepCycle(1);
    s.branch = 0;
    stepCycle(1);

    // Memory wait colliding with a branch; branch flushes once ready
    s.clr = 1;
    stepCycle(1);
    s = '0;
    s.mem_req = 1; s.branch = 1;
    repeat (3) stepCycle(1);
    s.mem_ready = 1;
    stepCycle(1);
    checkOne("memwait_cnt", stall_cnt_o, 16'd3);
    s = '0;
    stepCycle(1);
    stepCycle(1);

    // Random traffic
    repeat (400) begin
      randomStim();
      stepCycle(1);
    end

    // Async reset pulse while waiting on memory
    s = '0;
    s.mem_req = 1;
    repeat (2) stepCycle(1);
    applyStimulus(s);
    #2 reset_i = 1'b1;
    #1;
    checkOne("async_rst_cnt", stall_cnt_o, 16'd0);
    checkOne("async_rst_pc_en", {15'd0, pc_en_o}, 16'd1);
    reset_i = 1'b0;
    m_cnt = 0; m_shadow = 0;
    s.mem_req = 0;
    applyStimulus(s);
    @(negedge clk_i);
    stepCycle(1);

    // Async reset pulse inside the branch flush shadow drops the pending flush
    s.branch = 1;
    stepCycle(1);
    s.branch = 0;
    applyStimulus(s);
    #2 reset_i = 1'b1;
    #1 reset_i = 1'b0;
    m_cnt = 0; m_shadow = 0;
    @(negedge clk_i);
    stepCycle(1);
    checkOne("rst_flush_drop", {15'd0, flush_id_o}, 16'd0);

    // Saturation then clear during a stall
    s = '0;
    s.mem_req = 1;
    repeat (65534) stepCycle(0);
    repeat (3) stepCycle(1);
    checkOne("sat_cnt", stall_cnt_o, 16'hFFFF);
    s.clr = 1;
    stepCycle(1);
    s.clr = 0;
    stepCycle(1);
    checkOne("clr_cnt", stall_cnt_o, 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
